// File: rtl/bus_byte_mailbox_pkg.sv
// Shared constants for the byte mailbox: register offsets, STAT/CTRL/ERR bit
// positions, access FSM states and the write-lane helper.
package mbox_pkg;

    localparam logic [3:0] OFF_DATA = 4'h0;
    localparam logic [3:0] OFF_STAT = 4'h4;
    localparam logic [3:0] OFF_CTRL = 4'h8;
    localparam logic [3:0] OFF_ERR  = 4'hC;

    localparam int STAT_TX_FULL    = 0;
    localparam int STAT_TX_EMPTY   = 1;
    localparam int STAT_RX_EMPTY   = 2;
    localparam int STAT_RX_FULL    = 3;
    localparam int STAT_RX_CNT_LSB = 8;
    localparam int STAT_TX_CNT_LSB = 16;

    localparam int CTRL_RX_IRQ_EN  = 0;
    localparam int CTRL_TXE_IRQ_EN = 1;
    localparam int CTRL_CLR_TX     = 4;
    localparam int CTRL_CLR_RX     = 5;

    localparam int ERR_TX_OVF = 0;
    localparam int ERR_RX_UNF = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    // Byte from the lowest enabled lane; zero when no lane is enabled.
    function automatic logic [7:0] low_lane(
        input logic [3:0]  be,
        input logic [31:0] d
    );
        logic [7:0] b;
        b = 8'h00;
        for (int i = 3; i >= 0; i--) begin
            if (be[i]) b = d[8*i +: 8];
        end
        return b;
    endfunction

endpackage

// File: rtl/bus_byte_mailbox_if.sv
// Request/grant/response bus used by the mailbox register window.
interface bus_byte_mailbox_if;

    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req, we, addr, be, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output gnt, rvalid, rdata
    );

endinterface

// File: rtl/byte_fifo.sv
// Byte FIFO with synchronous clear; push is accepted when full if a pop
// happens in the same cycle.
module byte_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   clr,
    input  logic [7:0]             din,
    output logic [7:0]             dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & !empty;
    assign do_push = push & (!full | do_pop);
    assign dout    = mem[rptr];

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clr) mem[wptr] <= din;
    end

endmodule

// File: rtl/bus_byte_mailbox.sv
// Byte mailbox: 16-byte register window over TX/RX byte FIFOs with interrupt.
// Define MBOX_ERR_EN to build the sticky ERR register (tx overflow, rx underflow).
module bus_byte_mailbox
    import mbox_pkg::*;
#(
    parameter logic [31:0] addrBase = 32'h0,
    parameter int          DEPTH    = 8
) (
    input  logic                     Clk,
    input  logic                     Rst,
    bus_byte_mailbox_if.slave        bus,
    output logic [7:0]               tx_data,
    output logic                     tx_valid,
    input  logic                     tx_ready,
    input  logic [7:0]               rx_data,
    input  logic                     rx_valid,
    output logic                     rx_ready,
    output logic                     Int
);

    localparam int CW = $clog2(DEPTH) + 1;

    state_t        state;
    state_t        state_nx;
    logic          gnt;
    logic          rvalid;
    logic          hit;
    logic          acc;
    logic [3:0]    off;
    logic [7:0]    wbyte;
    logic          wr_data;
    logic          rd_data;
    logic          wr_ctrl;
    logic          rd_err;
    logic          rx_irq_en;
    logic          txe_irq_en;
    logic          clr_tx;
    logic          clr_rx;
    logic          tx_push;
    logic          tx_pop;
    logic          rx_push;
    logic          rx_pop;
    logic          tx_full;
    logic          tx_empty;
    logic          rx_full;
    logic          rx_empty;
    logic [7:0]    rx_head;
    logic [CW-1:0] tx_count;
    logic [CW-1:0] rx_count;
    logic [31:0]   stat_word;
    logic [31:0]   ctrl_word;
    logic [31:0]   err_word;
    logic [31:0]   rdata_q;
    logic [31:0]   rdata_nx;
    logic          unused_addr;

    assign unused_addr = ^bus.addr[1:0];

    assign hit   = (bus.addr[31:4] == addrBase[31:4]);
    assign off   = {bus.addr[3:2], 2'b00};
    assign wbyte = low_lane(bus.be, bus.wdata);
    assign acc   = gnt & hit & (|bus.be);

    always_ff @(posedge Clk) begin
        if (Rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        gnt      = 1'b0;
        rvalid   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (bus.req) state_nx = ST_GRANT;
            end
            ST_GRANT: begin
                gnt      = 1'b1;
                state_nx = ST_RESP;
            end
            ST_RESP: begin
                rvalid   = 1'b1;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign bus.gnt    = gnt;
    assign bus.rvalid = rvalid;
    assign bus.rdata  = rdata_q;

    always_comb begin
        stat_word = '0;
        stat_word[STAT_TX_FULL]  = tx_full;
        stat_word[STAT_TX_EMPTY] = tx_empty;
        stat_word[STAT_RX_EMPTY] = rx_empty;
        stat_word[STAT_RX_FULL]  = rx_full;
        stat_word[STAT_RX_CNT_LSB +: 8] = 8'(rx_count);
        stat_word[STAT_TX_CNT_LSB +: 8] = 8'(tx_count);
        ctrl_word = '0;
        ctrl_word[CTRL_RX_IRQ_EN]  = rx_irq_en;
        ctrl_word[CTRL_TXE_IRQ_EN] = txe_irq_en;
    end

    // Register decode; only meaningful while granting a hit with any byte lane.
    always_comb begin
        wr_data  = 1'b0;
        rd_data  = 1'b0;
        wr_ctrl  = 1'b0;
        rd_err   = 1'b0;
        rdata_nx = '0;
        if (acc) begin
            unique case (off)
                OFF_DATA: begin
                    if (bus.we) begin
                        wr_data = 1'b1;
                    end else begin
                        rd_data = 1'b1;
                        if (!rx_empty) rdata_nx = {4{rx_head}};
                    end
                end
                OFF_STAT: begin
                    if (!bus.we) rdata_nx = stat_word;
                end
                OFF_CTRL: begin
                    if (bus.we) wr_ctrl  = 1'b1;
                    else        rdata_nx = ctrl_word;
                end
                OFF_ERR: begin
                    if (!bus.we) begin
                        rd_err   = 1'b1;
                        rdata_nx = err_word;
                    end
                end
                default: rdata_nx = '0;
            endcase
        end
    end

    assign clr_tx   = wr_ctrl & wbyte[CTRL_CLR_TX];
    assign clr_rx   = wr_ctrl & wbyte[CTRL_CLR_RX];
    assign tx_push  = wr_data;
    assign tx_valid = !tx_empty;
    assign tx_pop   = tx_valid & tx_ready;
    assign rx_pop   = rd_data & !rx_empty;
    // A bus pop in this cycle frees a slot, so a full RX can still take a byte.
    assign rx_ready = !rx_full | rx_pop;
    assign rx_push  = rx_valid & rx_ready;

    byte_fifo #(.DEPTH(DEPTH)) u_tx (
        .clk   (Clk),
        .rst   (Rst),
        .push  (tx_push),
        .pop   (tx_pop),
        .clr   (clr_tx),
        .din   (wbyte),
        .dout  (tx_data),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    byte_fifo #(.DEPTH(DEPTH)) u_rx (
        .clk   (Clk),
        .rst   (Rst),
        .push  (rx_push),
        .pop   (rx_pop),
        .clr   (clr_rx),
        .din   (rx_data),
        .dout  (rx_head),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            rdata_q    <= '0;
            rx_irq_en  <= 1'b0;
            txe_irq_en <= 1'b0;
            Int        <= 1'b0;
        end else begin
            if (gnt) rdata_q <= rdata_nx;
            if (wr_ctrl) begin
                rx_irq_en  <= wbyte[CTRL_RX_IRQ_EN];
                txe_irq_en <= wbyte[CTRL_TXE_IRQ_EN];
            end
            Int <= (rx_irq_en & !rx_empty) | (txe_irq_en & tx_empty);
        end
    end

`ifdef MBOX_ERR_EN
    logic tx_ovf;
    logic rx_unf;

    always_ff @(posedge Clk) begin
        if (Rst || rd_err) begin
            tx_ovf <= 1'b0;
            rx_unf <= 1'b0;
        end else begin
            if (wr_data && tx_full && !tx_pop) tx_ovf <= 1'b1;
            if (rd_data && rx_empty)           rx_unf <= 1'b1;
        end
    end

    always_comb begin
        err_word = '0;
        err_word[ERR_TX_OVF] = tx_ovf;
        err_word[ERR_RX_UNF] = rx_unf;
    end
`else
    logic unused_err;

    assign unused_err = rd_err;
    assign err_word   = '0;
`endif

endmodule

// File: tb/tb_bus_byte_mailbox.sv
// Self-checking bench for bus_byte_mailbox: directed scenarios plus a random
// phase scored against queue-based TX/RX/CTRL/ERR model.
module tb_bus_byte_mailbox;

    localparam logic [31:0] BASE  = 32'h8000_0040;
    localparam int          DEPTH = 8;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       rx_ready;
    logic       Int;

    int checks   = 0;
    int failures = 0;

    logic [7:0] tx_m[$];
    logic [7:0] rx_m[$];
    logic [7:0] got_tx[$];
    bit         m_rxen;
    bit         m_txen;
    bit         m_ovf;
    bit         m_unf;

    bus_byte_mailbox_if bus ();

    bus_byte_mailbox #(
        .addrBase (BASE),
        .DEPTH    (DEPTH)
    ) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .bus      (bus),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .Int      (Int)
    );

    always #5 Clk = ~Clk;

    // Inputs only change just after a rising edge, so the falling edge sees
    // exactly what the next rising edge will use.
    always @(negedge Clk) begin
        if (tx_valid && tx_ready) got_tx.push_back(tx_data);
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    function automatic logic [31:0] addr_of(input logic [3:0] off);
        return BASE + {28'h0, off} + 32'($urandom_range(0, 3));
    endfunction

    function automatic logic [31:0] stat_exp();
        logic [31:0] s;
        s = '0;
        s[0]     = (tx_m.size() == DEPTH);
        s[1]     = (tx_m.size() == 0);
        s[2]     = (rx_m.size() == 0);
        s[3]     = (rx_m.size() == DEPTH);
        s[15:8]  = 8'(rx_m.size());
        s[23:16] = 8'(tx_m.size());
        return s;
    endfunction

    function automatic logic int_exp();
        return (m_rxen && rx_m.size() != 0) || (m_txen && tx_m.size() == 0);
    endfunction

    task automatic do_op(input logic w, input logic [31:0] a,
                         input logic [3:0] b, input logic [31:0] d,
                         output logic [31:0] rd);
        int gl;
        int rl;
        bus.req   = 1'b1;
        bus.we    = w;
        bus.addr  = a;
        bus.be    = b;
        bus.wdata = d;
        gl = -1;
        rl = -1;
        rd = 'x;
        for (int c = 1; c <= 8 && rl < 0; c++) begin
            @(posedge Clk);
            #1;
            if (bus.gnt && gl < 0) begin
                gl = c;
                bus.req = 1'b0;
            end
            if (bus.rvalid) begin
                rl = c;
                rd = bus.rdata;
            end
        end
        bus.req = 1'b0;
        chk("gnt_latency", gl, 1);
        chk("rvalid_latency", rl, 2);
        tick(1);
    endtask

    task automatic m_wr_data(input logic [7:0] v, input logic [3:0] b);
        logic [31:0] wd;
        logic [31:0] rd;
        int lo;
        wd = $urandom;
        lo = 0;
        for (int i = 3; i >= 0; i--) if (b[i]) lo = i;
        wd[8*lo +: 8] = v;
        do_op(1'b1, addr_of(4'h0), b, wd, rd);
        chk("wr_data_rdata", rd, 32'h0);
        if (tx_m.size() < DEPTH) tx_m.push_back(v);
        else m_ovf = 1'b1;
    endtask

    task automatic m_rd_data(input logic [3:0] b, output logic [31:0] rd);
        logic [31:0] exp;
        exp = 32'h0;
        if (rx_m.size() != 0) exp = {4{rx_m.pop_front()}};
        else m_unf = 1'b1;
        do_op(1'b0, addr_of(4'h0), b, $urandom, rd);
        chk("rd_data", rd, exp);
    endtask

    task automatic m_rd_stat(input string tag);
        logic [31:0] rd;
        do_op(1'b0, addr_of(4'h4), 4'hF, 32'h0, rd);
        chk(tag, rd, stat_exp());
    endtask

    task automatic m_rd_err(input string tag);
        logic [31:0] rd;
        logic [31:0] exp;
        exp = 32'h0;
`ifdef MBOX_ERR_EN
        exp = {30'h0, m_unf, m_ovf};
`endif
        m_ovf = 1'b0;
        m_unf = 1'b0;
        do_op(1'b0, addr_of(4'hC), 4'hF, 32'h0, rd);
        chk(tag, rd, exp);
    endtask

    task automatic m_wr_ctrl(input logic [7:0] v);
        logic [31:0] rd;
        do_op(1'b1, addr_of(4'h8), 4'h1, {24'h0, v}, rd);
        chk("wr_ctrl_rdata", rd, 32'h0);
        m_rxen = v[0];
        m_txen = v[1];
        if (v[4]) tx_m.delete();
        if (v[5]) rx_m.delete();
    endtask

    task automatic m_rd_ctrl(input string tag);
        logic [31:0] rd;
        do_op(1'b0, addr_of(4'h8), 4'hF, 32'h0, rd);
        chk(tag, rd, {30'h0, m_txen, m_rxen});
    endtask

    task automatic rx_send(input logic [7:0] v);
        rx_valid = 1'b1;
        rx_data  = v;
        @(posedge Clk);
        #1;
        rx_valid = 1'b0;
        if (rx_m.size() < DEPTH) rx_m.push_back(v);
    endtask

    task automatic drain_tx(input string tag);
        got_tx.delete();
        tx_ready = 1'b1;
        tick(DEPTH + 3);
        tx_ready = 1'b0;
        chk({tag, "_count"}, got_tx.size(), tx_m.size());
        for (int i = 0; i < got_tx.size() && i < tx_m.size(); i++)
            chk({tag, "_byte"}, {24'h0, got_tx[i]}, {24'h0, tx_m[i]});
        tx_m.delete();
    endtask

    initial begin
        logic [31:0] rd;
        logic [7:0]  exp_tx[$];
        int          seen;

        bus.req   = 1'b0;
        bus.we    = 1'b0;
        bus.addr  = 32'h0;
        bus.be    = 4'h0;
        bus.wdata = 32'h0;

        tick(3);
        Rst = 1'b0;
        chk("rst_gnt", bus.gnt, 0);
        chk("rst_rvalid", bus.rvalid, 0);
        chk("rst_rdata", bus.rdata, 0);
        chk("rst_int", Int, 0);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_rx_ready", rx_ready, 1);
        m_rd_stat("rst_stat");
        m_rd_ctrl("rst_ctrl");
        m_rd_err("rst_err");

        // TX stream ordering and lowest-lane write selection
        tx_ready = 1'b1;
        got_tx.delete();
        do_op(1'b1, addr_of(4'h0), 4'b0001, 32'hAABBCC63, rd);
        chk("wr63_rdata", rd, 0);
        do_op(1'b1, addr_of(4'h0), 4'b0001, 32'h0000006D, rd);
        do_op(1'b1, addr_of(4'h0), 4'b0001, 32'h12345664, rd);
        do_op(1'b1, addr_of(4'h0), 4'b1100, 32'h11223344, rd);
        tick(2);
        tx_ready = 1'b0;
        exp_tx = '{8'h63, 8'h6D, 8'h64, 8'h22};
        chk("tx_seq_count", got_tx.size(), exp_tx.size());
        for (int i = 0; i < got_tx.size() && i < exp_tx.size(); i++)
            chk("tx_seq_byte", {24'h0, got_tx[i]}, {24'h0, exp_tx[i]});
        m_rd_stat("tx_seq_stat");

        // TX overflow
        for (int i = 0; i < DEPTH + 1; i++)
            m_wr_data(8'($urandom), 4'b0001);
        m_rd_stat("tx_full_stat");
        m_rd_err("tx_ovf_err1");
        m_rd_err("tx_ovf_err2");
        drain_tx("tx_full_drain");

        // RX pop with lane replication and underflow
        rx_send(8'hA5);
        rx_send(8'h5A);
        m_rd_data(4'b0100, rd);
        chk("rx_lane2", rd & 32'h00FF0000, 32'h00A50000);
        m_rd_data(4'b0100, rd);
        m_rd_data(4'b0100, rd);
        m_rd_err("rx_unf_err");

        // Interrupt sources
        m_wr_ctrl(8'h01);
        m_rd_ctrl("ctrl_rx_en");
        tick(1);
        chk("int_rx_empty", Int, int_exp());
        rx_send(8'h33);
        tick(1);
        chk("int_rx_data", Int, int_exp());
        m_rd_data(4'b0001, rd);
        tick(1);
        chk("int_rx_popped", Int, int_exp());
        m_wr_ctrl(8'h02);
        tick(1);
        chk("int_tx_empty", Int, int_exp());
        m_wr_ctrl(8'h00);
        tick(1);
        chk("int_off", Int, int_exp());

        // RX full with a simultaneous stream push and bus pop, then clears
        for (int i = 0; i < DEPTH; i++) rx_send(8'($urandom));
        chk("rx_full_ready", rx_ready, 0);
        rx_valid = 1'b1;
        rx_data  = 8'hC3;
        m_rd_data(4'b0001, rd);
        rx_valid = 1'b0;
        rx_m.push_back(8'hC3);
        m_rd_stat("rx_push_pop_full");
        m_rd_data(4'b0001, rd);
        m_wr_ctrl(8'h20);
        m_rd_stat("rx_clear_stat");
        m_rd_ctrl("ctrl_clr_reads0");
        m_wr_data(8'h77, 4'b0010);
        m_wr_data(8'h78, 4'b0010);
        m_wr_ctrl(8'h10);
        m_rd_stat("tx_clear_stat");

        // Misses and empty byte enables have no side effect
        rx_send(8'h99);
        m_rd_stat("miss_base_stat");
        do_op(1'b0, BASE + 32'h10, 4'hF, 32'h0, rd);
        chk("miss_rd_rdata", rd, 0);
        do_op(1'b1, BASE + 32'h10, 4'h1, 32'h55, rd);
        chk("miss_wr_rdata", rd, 0);
        do_op(1'b0, addr_of(4'h0), 4'h0, 32'h0, rd);
        chk("be0_rdata", rd, 0);
        do_op(1'b1, addr_of(4'h0), 4'h0, 32'h66, rd);
        m_rd_stat("miss_after_stat");

        // Reset while in GRANT aborts the access
        bus.req   = 1'b1;
        bus.we    = 1'b1;
        bus.addr  = addr_of(4'h8);
        bus.be    = 4'h1;
        bus.wdata = 32'h3;
        tick(1);
        chk("rst_grant_gnt", bus.gnt, 1);
        Rst     = 1'b1;
        bus.req = 1'b0;
        tick(1);
        Rst = 1'b0;
        chk("rst_grant_rvalid", bus.rvalid, 0);
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            tick(1);
            if (bus.rvalid || bus.gnt) seen++;
        end
        chk("rst_grant_no_resp", seen, 0);
        rx_m.delete();
        tx_m.delete();
        m_rxen = 1'b0;
        m_txen = 1'b0;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
        m_rd_ctrl("rst_grant_ctrl");
        m_rd_stat("rst_grant_stat");

        // Random traffic against the model
        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 4))
                0: m_wr_data(8'($urandom), 4'($urandom_range(1, 15)));
                1: m_rd_data(4'($urandom_range(1, 15)), rd);
                2: m_rd_stat("rand_stat");
                3: rx_send(8'($urandom));
                default: m_rd_err("rand_err");
            endcase
        end
        m_rd_stat("rand_final_stat");
        drain_tx("rand_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
